// File: rtl/softmax_req_arbiter.sv
// Round-robin arbiter that shares one softmax engine between NUM_REQ streams.
// Optional WAIT_END watchdog is enabled with `define SOFTMAX_ARB_TIMEOUT_EN.
module softmax_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int IFM_SIZE       = 10,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [2:0]                    active_id,
  output logic [NUM_REQ-1:0]            done,
  output logic                          abort,
  output logic                          timeout,
  output logic                          busy,
  output logic                          sm_valid_ifm,
  output logic [DATA_WIDTH-1:0]         sm_ifm,
  input  logic                          sm_end_softmax,
  output logic                          sm_clr
);
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(IFM_SIZE + 1);
  localparam int KW  = $clog2(CLR_CYCLES + 1);
  localparam logic [CW-1:0] W_LAST   = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] W_FULL   = CW'(IFM_SIZE);
  localparam logic [KW-1:0] CLR_LAST = KW'(CLR_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CLR_CYCLES < 1 || IFM_SIZE < 1 || TIMEOUT_CYCLES < 1)
    $error("softmax_req_arbiter: parameter out of range");

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT_END, S_RELEASE, S_CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          wcnt_q, wcnt_d;
  logic [KW-1:0]          clr_cnt_q, clr_cnt_d;
  logic [IW-1:0]          last_id_q, last_id_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d, done_q, done_d;
  logic [2:0]             active_id_q, active_id_d;
  logic                   abort_q, abort_d, busy_q, busy_d;
  logic                   sm_valid_q, sm_valid_d, sm_clr_q, sm_clr_d;
  logic [DATA_WIDTH-1:0]  sm_ifm_q, sm_ifm_d;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
`endif

  logic [IW-1:0] act_idx;
  assign act_idx = active_id_q[IW-1:0];

  // Round-robin scan starts just after the last requester that completed.
  logic [IW-1:0] pick, idx;
  logic          found;
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IW'((int'(last_id_q) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Ready is gated by req so no word is taken in the cycle a job is dropped.
  always_comb begin
    req_ready = '0;
    if (state_q == S_STREAM && wcnt_q < W_FULL && req[act_idx])
      req_ready[act_idx] = req_valid[act_idx];
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    clr_cnt_d   = clr_cnt_q;
    last_id_d   = last_id_q;
    grant_d     = grant_q;
    active_id_d = active_id_q;
    done_d      = '0;
    abort_d     = 1'b0;
    sm_valid_d  = 1'b0;
    sm_ifm_d    = sm_ifm_q;
    sm_clr_d    = 1'b0;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = NUM_REQ'(1) << pick;
          active_id_d = 3'(pick);
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!req[act_idx]) begin
          abort_d   = 1'b1;
          grant_d   = '0;
          sm_clr_d  = 1'b1;
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end else if (|req_ready) begin
          sm_valid_d = 1'b1;
          sm_ifm_d   = req_data[act_idx*DATA_WIDTH +: DATA_WIDTH];
          wcnt_d     = wcnt_q + 1'b1;
          if (wcnt_q == W_LAST) begin
            state_d = S_WAIT_END;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end
      S_WAIT_END: begin
        if (sm_end_softmax) begin
          done_d    = grant_q;
          grant_d   = '0;
          last_id_d = act_idx;
          state_d   = S_RELEASE;
        end
`ifdef SOFTMAX_ARB_TIMEOUT_EN
        else if (wait_cnt_q == T_LAST) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          sm_clr_d  = 1'b1;
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        sm_clr_d  = 1'b1;
        clr_cnt_d = '0;
        state_d   = S_CLEAR;
      end
      S_CLEAR: begin
        wcnt_d = '0;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          sm_clr_d  = 1'b1;
        end
      end
      default: begin
        sm_clr_d  = 1'b1;
        clr_cnt_d = '0;
        state_d   = S_CLEAR;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      wcnt_q      <= '0;
      clr_cnt_q   <= '0;
      last_id_q   <= IW'(NUM_REQ - 1);
      grant_q     <= '0;
      active_id_q <= '0;
      done_q      <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      sm_valid_q  <= 1'b0;
      sm_ifm_q    <= '0;
      sm_clr_q    <= 1'b1;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      clr_cnt_q   <= clr_cnt_d;
      last_id_q   <= last_id_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      sm_valid_q  <= sm_valid_d;
      sm_ifm_q    <= sm_ifm_d;
      sm_clr_q    <= sm_clr_d;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign active_id    = active_id_q;
  assign done         = done_q;
  assign abort        = abort_q;
  assign busy         = busy_q;
  assign sm_valid_ifm = sm_valid_q;
  assign sm_ifm       = sm_ifm_q;
  assign sm_clr       = sm_clr_q;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_req_arbiter.sv
// Directed bench for softmax_req_arbiter: single job, round-robin, valid gaps,
// abort, mid-stream reset and WAIT_END watchdog / indefinite wait.
module tb_softmax_req_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0, req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              sm_end_softmax = 1'b0;
  logic [NR-1:0]     req_ready, grant, done;
  logic [2:0]        active_id;
  logic              abort, timeout, busy, sm_valid_ifm, sm_clr;
  logic [DW-1:0]     sm_ifm;

`ifdef SOFTMAX_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  softmax_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IFM_SIZE(10),
                        .CLR_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .active_id(active_id), .done(done),
    .abort(abort), .timeout(timeout), .busy(busy), .sm_valid_ifm(sm_valid_ifm),
    .sm_ifm(sm_ifm), .sm_end_softmax(sm_end_softmax), .sm_clr(sm_clr));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Granted lane carries base+k; other lanes carry a distinct junk pattern.
  task automatic set_data(input int id, input int base, input int k);
    for (int i = 0; i < NR; i++)
      req_data[i*DW +: DW] = (i == id) ? DW'(base + k) : DW'(32'hBAD0_0000 + i*16 + k);
  endtask

  task automatic reset_dut;
    rst = 1'b1; req = '0; req_valid = '0; sm_end_softmax = 1'b0;
    tick; tick;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_active_id", 64'(active_id), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_abort", 64'(abort), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sm_valid", 64'(sm_valid_ifm), 64'd0);
    chk("rst_sm_ifm", 64'(sm_ifm), 64'd0);
    chk("rst_sm_clr", 64'(sm_clr), 64'd1);
    rst = 1'b0;
    tick;
    chk("rst_clr1", 64'(sm_clr), 64'd1);
    tick;
    chk("rst_idle_clr", 64'(sm_clr), 64'd0);
    chk("rst_idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic grant_chk(input int id);
    tick;
    chk("grant", 64'(grant), 64'(1 << id));
    chk("active_id", 64'(active_id), 64'(id));
    chk("grant_busy", 64'(busy), 64'd1);
  endtask

  task automatic stream(input int id, input int base, input int n, input bit allv, input bit gap);
    for (int k = 0; k < n; k++) begin
      req_valid = allv ? '1 : NR'(1 << id);
      set_data(id, base, k);
      settle;
      chk("req_ready", 64'(req_ready), 64'(1 << id));
      tick;
      chk("sm_valid", 64'(sm_valid_ifm), 64'd1);
      chk("sm_ifm", 64'(sm_ifm), 64'(base + k));
      if (gap) begin
        req_valid = '0;
        settle;
        chk("gap_ready", 64'(req_ready), 64'd0);
        tick;
        chk("gap_valid", 64'(sm_valid_ifm), 64'd0);
      end
    end
    req_valid = '0;
  endtask

  // Entered in WAIT_END; engine ends on the delay-th edge after the last word.
  task automatic finish(input int id, input int delay);
    req_valid = '1;
    settle;
    chk("wait_no_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    for (int d = 1; d < delay; d++) begin
      tick;
      chk("wait_no_valid", 64'(sm_valid_ifm), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_no_done", 64'(done), 64'd0);
    end
    sm_end_softmax = 1'b1;
    tick;
    sm_end_softmax = 1'b0;
    chk("done", 64'(done), 64'(1 << id));
    chk("rel_grant", 64'(grant), 64'd0);
    chk("rel_clr", 64'(sm_clr), 64'd0);
    tick;
    chk("clr0_done", 64'(done), 64'd0);
    chk("clr0", 64'(sm_clr), 64'd1);
    tick;
    chk("clr1", 64'(sm_clr), 64'd1);
    tick;
    chk("idle_clr", 64'(sm_clr), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_grant", 64'(grant), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rr_order[4];
    rr_order = '{0, 1, 3, 0};

    reset_dut;

    // Single job from requester 2
    req = 4'b0100;
    grant_chk(2);
    stream(2, 32'h100, 10, 1'b0, 1'b0);
    finish(2, 2);
    req = '0;
    tick;
    chk("stay_idle", 64'(grant), 64'd0);

    // Round-robin with last_id reset to 3
    reset_dut;
    req = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      grant_chk(rr_order[j]);
      stream(rr_order[j], 32'h200 + j*32'h20, 10, 1'b1, 1'b0);
      finish(rr_order[j], 5);
    end
    req = '0;

    // Alternating valid; last_id is 0 so requester 0 wins after a full scan
    req = 4'b0001;
    grant_chk(0);
    stream(0, 32'h300, 10, 1'b0, 1'b1);
    finish(0, 1);
    req = '0;

    // Abort keeps priority position
    reset_dut;
    req = 4'b0010;
    grant_chk(1);
    stream(1, 32'h400, 4, 1'b0, 1'b0);
    req = '0;
    tick;
    chk("abort", 64'(abort), 64'd1);
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_clr0", 64'(sm_clr), 64'd1);
    tick;
    chk("abort_pulse", 64'(abort), 64'd0);
    chk("abort_clr1", 64'(sm_clr), 64'd1);
    tick;
    chk("abort_idle_clr", 64'(sm_clr), 64'd0);
    req = 4'b0110;
    grant_chk(1);
    req = '0;
    tick;
    chk("abort2", 64'(abort), 64'd1);
    tick; tick;
    req = 4'b0011;
    grant_chk(0);

    // Reset in the middle of a stream
    stream(0, 32'h500, 6, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    chk("mrst_grant", 64'(grant), 64'd0);
    chk("mrst_valid", 64'(sm_valid_ifm), 64'd0);
    chk("mrst_clr", 64'(sm_clr), 64'd1);
    rst = 1'b0;
    tick;
    chk("mrst_clr1", 64'(sm_clr), 64'd1);
    chk("mrst_grant1", 64'(grant), 64'd0);
    tick;
    chk("mrst_idle_clr", 64'(sm_clr), 64'd0);
    chk("mrst_idle_busy", 64'(busy), 64'd0);
    grant_chk(0);

    // Engine never ends
    stream(0, 32'h600, 10, 1'b0, 1'b0);
`ifdef SOFTMAX_ARB_TIMEOUT_EN
    for (int c = 2; c <= 20; c++) tick;
    chk("to_not_yet", 64'(timeout), 64'd0);
    chk("to_busy", 64'(busy), 64'd1);
    tick;
    chk("timeout", 64'(timeout), 64'd1);
    chk("to_grant", 64'(grant), 64'd0);
    chk("to_no_done", 64'(done), 64'd0);
    chk("to_clr0", 64'(sm_clr), 64'd1);
    tick;
    chk("to_pulse", 64'(timeout), 64'd0);
    chk("to_clr1", 64'(sm_clr), 64'd1);
    tick;
    chk("to_idle_clr", 64'(sm_clr), 64'd0);
    chk("to_idle_busy", 64'(busy), 64'd0);
`else
    for (int c = 0; c < 100; c++) tick;
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_grant", 64'(grant), 64'd1);
    chk("hang_timeout", 64'(timeout), 64'd0);
    chk("hang_clr", 64'(sm_clr), 64'd0);
    chk("hang_done", 64'(done), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/softmax_req_arbiter.md
Name: softmax_req_arbiter

Overview:
- Shares one softmax engine between NUM_REQ requesters, such as per-layer conv result streams.
- Grants the engine round-robin and streams exactly IFM_SIZE words from the granted requester into the engine.
- Waits for the engine's end_softmax, reports completion, then clears the engine so it is ready for the next job.
- Sits between the convolution output buffers and the softmax controller/datapath in the classification stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, word width of each requester stream.
- IFM_SIZE, 10, words per softmax job.
- CLR_CYCLES, 2, cycles the engine clear is held after each job (>=1).
- TIMEOUT_CYCLES, 1023, WAIT_END watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  level request per requester; must stay high until done/abort
- req_valid  input  NUM_REQ  data-valid per requester
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  word accepted this cycle (combinational; one-hot or zero)
- grant  output  NUM_REQ  registered one-hot grant
- active_id  output  3  index of the granted requester
- done  output  NUM_REQ  1-cycle pulse when the granted job completes
- abort  output  1  1-cycle pulse when a job is dropped
- timeout  output  1  1-cycle pulse on watchdog expiry
- busy  output  1  high in every state except IDLE
- sm_valid_ifm  output  1  registered word strobe to the engine
- sm_ifm  output  DATA_WIDTH  registered word to the engine
- sm_end_softmax  input  1  engine finished
- sm_clr  output  1  active-high engine clear; the top level drives the engine's rst_n with ~sm_clr

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: grant=0, active_id=0, done=0, abort=0, timeout=0, busy=0, sm_valid_ifm=0, sm_ifm=0, sm_clr=1, state=CLEAR with clear counter=0, last_id=NUM_REQ-1, word counter=0.
- A reset asserted mid-job overrides everything in that cycle. After release, the block runs a full CLEAR before IDLE.

State machine:
- IDLE:
  - If req != 0, select the first set bit scanning last_id+1, last_id+2, ... modulo NUM_REQ.
  - Register grant (one-hot) and active_id; go to STREAM.
  - With no requests, stay in IDLE.
- STREAM:
  - req_ready[active_id] = req_valid[active_id] while word counter < IFM_SIZE; all other req_ready bits are 0.
  - On each accepted word, the next cycle has sm_ifm = that word and sm_valid_ifm=1 (latency 1). The word counter increments.
  - Gaps in req_valid are allowed: sm_valid_ifm=0 and the counter holds.
  - When the IFM_SIZE-th word is accepted, go to WAIT_END.
  - If req[active_id] drops before that, pulse abort, drop grant, go to CLEAR; words already sent are not recalled.
- WAIT_END:
  - sm_valid_ifm=0. On sm_end_softmax=1, go to RELEASE.
  - If sm_end_softmax is already high on entry, it counts on the first WAIT_END cycle.
- RELEASE (1 cycle):
  - done[active_id]=1 and grant drops to 0; last_id <= active_id; go to CLEAR.
- CLEAR:
  - sm_clr=1 for CLR_CYCLES cycles; the word counter resets; then go to IDLE.
  - sm_clr=0 in all other states.

Other rules:
- last_id updates only on RELEASE. An aborted requester keeps its priority position.
- A requester raising req while another job runs simply waits; there is no preemption.
- Word counter width is clog2(IFM_SIZE+1). It never wraps: it saturates at IFM_SIZE and is cleared in CLEAR.
- At most one of done, abort and timeout pulses in any cycle.

Optional Feature:
- Macro: SOFTMAX_ARB_TIMEOUT_EN.
- Defined: a WAIT_END cycle counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES without sm_end_softmax, pulse timeout, drop grant without done, go to CLEAR. last_id is unchanged.
- Not defined: no counter is built, timeout is tied to 0, and WAIT_END waits indefinitely.

Test Plan:
- Single job: NUM_REQ=4, IFM_SIZE=10, req[2]=1, valid every cycle with data 0x100..0x109. Expect grant=0b0100; sm_ifm 0x100..0x109 on 10 consecutive cycles, each 1 cycle after its req_ready. After sm_end_softmax, expect done[2] for 1 cycle, then sm_clr high 2 cycles, then IDLE.
- Round-robin: req=0b1011 held, engine model ends 5 cycles after the last word. Expect grant order 0,1,3,0; done pulses in the same order; the gap between jobs is exactly 1 RELEASE + 2 CLEAR + 1 IDLE cycles.
- Valid gaps: req_valid[0] toggles 1,0,1,0 across 20 cycles. Expect exactly 10 sm_valid_ifm pulses, req_ready only where req_valid=1, and WAIT_END entered after the 10th word.
- Abort: req[1] drops after 4 words. Expect abort pulse, no done, sm_clr 2 cycles, last_id unchanged; with req=0b0011 the next grant is requester 1 again only if 0 is not earlier in scan order (last_id=3, so grant=0).
- Reset mid-stream: assert rst for 1 cycle at word 6. Expect the next cycle grant=0, sm_valid_ifm=0, sm_clr=1; after release, sm_clr stays high for 2 cycles, then IDLE, then re-grant from requester 0.
- With SOFTMAX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, sm_end_softmax never asserts. Expect a timeout pulse on WAIT_END cycle 20, no done, then CLEAR then IDLE. Without the macro, the block is still in WAIT_END with busy=1 after 100 cycles.
